fifo_window_drain: RTL
======================

Name: fifo_window_drain

Overview:
- Downstream consumer of the asynchronous m-word FIFO buffer.
- Watches the FIFO's full flag. On its rising edge, snapshots the full m-word parallel window in one cycle, then streams the words out one per beat on a valid/ready interface, oldest word (index 0) first.
- Accumulates a modulo-2^n checksum over the streamed words.
- After the last beat, pulses a read request back to the FIFO so the FIFO can release or refill the window.

Parameters:
- n, 32, data word width in bits.
- m, 16, window depth in words; must be ≥2 and a power of two.
- address, 4, index width in bits; must equal log2(m).

Ports:
- clk_i  in  1  single system clock; all logic is rising-edge.
- rst_i  in  1  asynchronous, active-high reset.
- win_i  in  n x [0:m-1]  parallel FIFO window; [0] is the oldest word.
- full_i  in  1  FIFO full flag; asynchronous to clk_i, so it is synchronized internally.
- ready_i  in  1  sink ready.
- dout_o  out  n  streamed word.
- valid_o  out  1  dout_o valid.
- last_o  out  1  marks the final word of a window (index m-1).
- idx_o  out  address  index of the current word.
- rd_req_o  out  1  one-cycle pulse to the FIFO read enable after the window is drained.
- sum_o  out  n  checksum of the last completed window.
- sum_vld_o  out  1  one-cycle pulse when sum_o updates.
- busy_o  out  1  high while not IDLE.
- ovr_o  out  1  sticky overrun flag.

Behaviour:
- Reset (asynchronous, active-high on rst_i):
  - All outputs go to 0.
  - State goes to IDLE; shadow registers, index, accumulator and synchronizer flops are cleared.
  - Reset asserted mid-stream aborts the window: no rd_req_o, no sum_vld_o.
- Synchronizer and edge detect:
  - full_i passes through 2 flops to give full_s; full_s_d is the previous full_s.
  - The start event is full_s & ~full_s_d.
- Latency: full_i high before edge E gives full_s high after E+1. The start event captures the window at E+2, and valid_o is high after E+2, i.e. a 3-cycle latency.
- IDLE:
  - On the start event: shadow[0:m-1] <= win_i, idx <= 0, acc <= 0, next state STREAM.
  - Otherwise stay in IDLE.
- STREAM:
  - valid_o = 1; dout_o = shadow[idx]; idx_o = idx; last_o = (idx == m-1).
  - On each beat (valid_o & ready_i): acc <= acc + shadow[idx], truncated to n bits.
  - On a beat with idx < m-1: idx <= idx + 1.
  - On a beat with idx == m-1: go to DONE.
  - With ready_i low, all outputs hold; no beats are dropped.
- DONE (exactly 1 cycle):
  - rd_req_o = 1, sum_o <= acc, sum_vld_o = 1, then go to IDLE.
  - valid_o = 0.
- Back-to-back windows: if full_s is still high on return to IDLE, no new start occurs. A new window requires a new rising edge of full_s.
- Overrun: a start event seen while not in IDLE sets ovr_o = 1. That event is ignored and the current window continues. ovr_o clears only on reset.
- idx arithmetic is address bits wide with no wrap beyond m-1. The checksum wraps modulo 2^n.
- win_i is sampled only on the start event. Changes to win_i during STREAM have no effect.

Decomposition:
- Package fifo_drain_pkg:
  - typedef state_t enum {IDLE, STREAM, DONE}.
  - A localparam for the synchronizer depth (2).
- One sub-module, sync2_n: a 2-flop synchronizer with parameterised width and async active-high reset to 0. It is reused for full_i.
- Shadow registers, FSM, index and accumulator stay in the top module.

Test Plan:
- Reset, then a full_i rising edge with win_i[k]=k+1, n=32, m=16, ready_i=1:
  - valid_o rises 3 cycles after the edge, followed by 16 beats with dout_o = 1..16.
  - last_o is high only on the beat with dout_o = 16.
  - The next cycle has rd_req_o = 1, sum_vld_o = 1, sum_o = 136.
- Same window with ready_i toggling 1,0,1,0:
  - dout_o holds during ready_i = 0, taking 32 cycles in total.
  - Sequence, sum and last_o are identical to the first test.
- win_i[k] = 32'hFFFF_FFFF for all k:
  - sum_o = 32'hFFFF_FFF0 (wrap-around).
- A second full_i rising edge mid-stream:
  - ovr_o goes to 1 and stays there.
  - The first window completes unchanged.
  - No second window starts until a later full_s edge.
- rst_i asserted at beat 5:
  - All outputs are 0 immediately.
  - No rd_req_o or sum_vld_o occurs.
  - After release, a new full edge drains the new window starting from index 0.
- full_i held high across the DONE state:
  - No restart occurs.
  - Dropping full_i and raising it again starts a new window.

Source files
------------

// File: rtl/fifo_drain_pkg.sv
// Shared types and constants for the FIFO window drain block.
package fifo_drain_pkg;

    localparam int SYNC_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE,
        STREAM,
        DONE
    } state_t;

endpackage

// File: rtl/fifo_window_drain_sync2_n.sv
// Multi-flop synchronizer for slow asynchronous level signals.
module sync2_n
    import fifo_drain_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [SYNC_DEPTH-1:0][W-1:0] chain_q;
    logic [SYNC_DEPTH-1:0][W-1:0] chain_d;

    always_comb begin
        chain_d = {chain_q[SYNC_DEPTH-2:0], d_i};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            chain_q <= '0;
        end else begin
            chain_q <= chain_d;
        end
    end

    assign q_o = chain_q[SYNC_DEPTH-1];

endmodule

// File: rtl/fifo_window_drain.sv
// Snapshots a full FIFO window, streams it out word by word with a
// running checksum, then requests the FIFO to release the window.
module fifo_window_drain
    import fifo_drain_pkg::*;
#(
    parameter int n       = 32,
    parameter int m       = 16,
    parameter int address = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [m-1:0][n-1:0]  win_i,
    input  logic                 full_i,
    input  logic                 ready_i,
    output logic [n-1:0]         dout_o,
    output logic                 valid_o,
    output logic                 last_o,
    output logic [address-1:0]   idx_o,
    output logic                 rd_req_o,
    output logic [n-1:0]         sum_o,
    output logic                 sum_vld_o,
    output logic                 busy_o,
    output logic                 ovr_o
);

    localparam logic [address-1:0] LAST_IDX = address'(m - 1);

    state_t               state_q, state_d;
    logic [m-1:0][n-1:0]  shadow_q, shadow_d;
    logic [address-1:0]   idx_q, idx_d;
    logic [n-1:0]         acc_q, acc_d;
    logic [n-1:0]         sum_q, sum_d;
    logic                 ovr_q, ovr_d;
    logic                 full_s_d_q, full_s_d_d;
    logic                 full_s;
    logic                 start;
    logic                 at_last;
    logic                 streaming;

    sync2_n #(
        .W (1)
    ) u_full_sync (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (full_i),
        .q_o   (full_s)
    );

    assign start     = full_s & ~full_s_d_q;
    assign at_last   = (idx_q == LAST_IDX);
    assign streaming = (state_q == STREAM);

    always_comb begin
        state_d    = state_q;
        shadow_d   = shadow_q;
        idx_d      = idx_q;
        acc_d      = acc_q;
        sum_d      = sum_q;
        ovr_d      = ovr_q;
        full_s_d_d = full_s;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shadow_d = win_i;
                    idx_d    = '0;
                    acc_d    = '0;
                    state_d  = STREAM;
                end
            end
            STREAM: begin
                if (ready_i) begin
                    acc_d = acc_q + shadow_q[idx_q];
                    if (at_last) begin
                        // publish the sum together with the DONE pulse
                        sum_d   = acc_d;
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (start && (state_q != IDLE)) begin
            ovr_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            shadow_q   <= '0;
            idx_q      <= '0;
            acc_q      <= '0;
            sum_q      <= '0;
            ovr_q      <= 1'b0;
            full_s_d_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            idx_q      <= idx_d;
            acc_q      <= acc_d;
            sum_q      <= sum_d;
            ovr_q      <= ovr_d;
            full_s_d_q <= full_s_d_d;
        end
    end

    assign valid_o   = streaming;
    assign dout_o    = streaming ? shadow_q[idx_q] : '0;
    assign idx_o     = streaming ? idx_q : '0;
    assign last_o    = streaming & at_last;
    assign rd_req_o  = (state_q == DONE);
    assign sum_vld_o = (state_q == DONE);
    assign sum_o     = sum_q;
    assign busy_o    = (state_q != IDLE);
    assign ovr_o     = ovr_q;

endmodule
